// File: rtl/register_unit.sv
// register_unit: RV32I integer register file with a valid/ready debug dump engine (optional RU_WRITE_BYPASS_EN)
module register_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            RUWr,
  input  logic [XLEN-1:0] DataWr,
  output logic [XLEN-1:0] RURs1,
  output logic [XLEN-1:0] RURs2,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy,
  output logic            dump_done
);
  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [4:0]      r_idx, w_idx_next;
  logic            w_we;
  logic [XLEN-1:0] w_rd1, w_rd2;
  assign w_we  = RUWr && rd != 5'd0;
  assign w_rd1 = rs1 == 5'd0 ? '0 : r_regs[rs1];
  assign w_rd2 = rs2 == 5'd0 ? '0 : r_regs[rs2];
`ifdef RU_WRITE_BYPASS_EN
  assign RURs1 = (w_we && rd == rs1) ? DataWr : w_rd1;
  assign RURs2 = (w_we && rd == rs2) ? DataWr : w_rd2;
`else
  assign RURs1 = w_rd1;
  assign RURs2 = w_rd2;
`endif
  // register file storage; x0 is never written
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (w_we) r_regs[rd] <= DataWr;
  // dump engine state and beat index
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  // next state: start only from IDLE, advance on each accepted beat
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      IDLE: if (dump_start) begin
        w_next     = DUMP;
        w_idx_next = '0;
      end
      DUMP: if (dump_ready) begin
        if (r_idx == 5'(NREGS - 1)) w_next = DONE;
        else w_idx_next = r_idx + 5'd1;
      end
      DONE: begin
        w_next     = IDLE;
        w_idx_next = '0;
      end
      default: begin
        w_next     = IDLE;
        w_idx_next = '0;
      end
    endcase
  end
  assign dump_valid = r_state == DUMP;
  assign dump_idx   = dump_valid ? r_idx : 5'd0;
  assign dump_data  = (dump_valid && r_idx != 5'd0) ? r_regs[r_idx] : '0;
  assign dump_busy  = r_state != IDLE;
  assign dump_done  = r_state == DONE;
endmodule

// File: tb/tb_register_unit.sv
// tb_register_unit: scoreboard bench for register_unit reads, writes and dump engine
module tb_register_unit;
  logic        clk = 0, rst_n = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0;
  logic        RUWr = 0, dump_start = 0, dump_ready = 0;
  logic [31:0] DataWr = 0;
  logic [31:0] RURs1, RURs2, dump_data;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_idx;
  int          n_cmp = 0, n_err = 0;
  logic [4:0]  q_idx[$];
  logic [31:0] q_data[$];
  logic [31:0] mdl [32];
  bit          prev_last = 0, prev_done = 0;

  register_unit dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd), .RUWr(RUWr), .DataWr(DataWr),
    .RURs1(RURs1), .RURs2(RURs2), .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // monitor: every presented beat is checked against the queue front; accepted beats pop it
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_last = 0;
      prev_done = 0;
    end else begin
      if (prev_last || dump_done) check("done_pulse", {31'd0, dump_done}, {31'd0, prev_last});
      if (prev_done) check("busy_after_done", {31'd0, dump_busy}, 32'd0);
      prev_done = dump_done;
      prev_last = 0;
      if (dump_valid) begin
        if (q_idx.size() == 0) fail("unexpected_beat");
        else begin
          check("beat_idx", {27'd0, dump_idx}, {27'd0, q_idx[0]});
          check("beat_data", dump_data, q_data[0]);
          if (dump_ready) begin
            prev_last = q_idx[0] == 5'd31;
            void'(q_idx.pop_front());
            void'(q_data.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    RUWr = 1; rd = a; DataWr = d;
    tick();
    RUWr = 0;
    if (a != 0) mdl[a] = d;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) begin
      q_idx.push_back(5'(i));
      q_data.push_back(i == 0 ? 32'd0 : mdl[i]);
    end
  endtask

  task automatic start();
    dump_start = 1;
    tick();
    dump_start = 0;
  endtask

  task automatic finish_dump(bit toggle);
    for (int c = 0; c < 200; c++) begin
      if (!dump_busy) break;
      if (toggle) dump_ready = ~dump_ready;
      tick();
    end
    if (dump_busy) fail("dump_timeout");
    check("beats_left", q_idx.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    tick(); tick();
    check("rst_busy", {31'd0, dump_busy}, 0);
    check("rst_valid", {31'd0, dump_valid}, 0);
    check("rst_done", {31'd0, dump_done}, 0);
    check("rst_idx", {27'd0, dump_idx}, 0);
    rst_n = 1;
    rs1 = 5; rs2 = 31; #1;
    check("rst_rs1", RURs1, 0);
    check("rst_rs2", RURs2, 0);
    // dump straight out of reset
    push_dump();
    dump_ready = 1;
    start();
    finish_dump(0);
    // write x5, observe same-cycle and next-cycle reads
    rs1 = 5; RUWr = 1; rd = 5; DataWr = 32'h12345678; #1;
`ifdef RU_WRITE_BYPASS_EN
    check("same_cycle_rs1", RURs1, 32'h12345678);
`else
    check("same_cycle_rs1", RURs1, 32'h0);
`endif
    tick();
    RUWr = 0; mdl[5] = 32'h12345678;
    check("next_cycle_rs1", RURs1, 32'h12345678);
    // write to x0 is discarded, also during the write cycle
    rs1 = 0; rs2 = 0; RUWr = 1; rd = 0; DataWr = 32'hCAFEBABE; #1;
    check("x0_during_wr", RURs1, 0);
    tick();
    RUWr = 0;
    check("x0_rs1", RURs1, 0);
    check("x0_rs2", RURs2, 0);
    // fill x1..x31 then dump with ready toggling every cycle
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h100 + i);
    rs1 = 7; rs2 = 31; #1;
    check("rd_x7", RURs1, 32'h107);
    check("rd_x31", RURs2, 32'h11F);
    push_dump();
    dump_ready = 0;
    start();
    finish_dump(1);
    // stall at idx 3, overwrite x3 and retry start
    push_dump();
    dump_ready = 1;
    start();
    tick(); tick(); tick();
    dump_ready = 0;
    check("stall_idx", {27'd0, dump_idx}, 3);
    RUWr = 1; rd = 3; DataWr = 32'hDEADBEEF; dump_start = 1;
    tick();
    RUWr = 0; dump_start = 0; mdl[3] = 32'hDEADBEEF; q_data[0] = 32'hDEADBEEF;
    check("restart_ignored_idx", {27'd0, dump_idx}, 3);
    check("stall_data_tracks_wr", dump_data, 32'hDEADBEEF);
    dump_ready = 1;
    finish_dump(0);
    // reset in the middle of a dump
    push_dump();
    dump_ready = 1;
    start();
    for (int c = 0; c < 64 && dump_idx != 5'd10; c++) tick();
    check("reach_idx10", {27'd0, dump_idx}, 10);
    rst_n = 0;
    tick();
    check("midrst_busy", {31'd0, dump_busy}, 0);
    check("midrst_valid", {31'd0, dump_valid}, 0);
    check("midrst_done", {31'd0, dump_done}, 0);
    rst_n = 1;
    q_idx.delete();
    q_data.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(32 - i); #1;
      check("midrst_rs1", RURs1, 0);
      check("midrst_rs2", RURs2, 0);
    end
    tick(); tick();
    check("idle_after_rst", {31'd0, dump_busy}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- Architectural integer register file (x0..x31) for the monocycle RISC-V core.
- Sits directly downstream of the write-back source mux and consumes its 32-bit DataWr result. Supplies rs1/rs2 operands to the ALU and branch stages.
- Adds a sequential debug dump engine that streams all 32 registers over a valid/ready handshake, used for bench self-checking and board bring-up.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; fixed at 32 for RV32I. Index width is 5 bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rs1  in  5  read address, port 1.
- rs2  in  5  read address, port 2.
- rd  in  5  write address.
- RUWr  in  1  write enable from the control unit.
- DataWr  in  XLEN  write data from the write-back mux.
- RURs1  out  XLEN  read data, port 1.
- RURs2  out  XLEN  read data, port 2.
- dump_start  in  1  one-cycle request to begin a register dump.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_valid  out  1  dump beat valid.
- dump_idx  out  5  register index of the current beat.
- dump_data  out  XLEN  register contents of the current beat.
- dump_busy  out  1  high while the engine is not IDLE.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst_n low at a rising edge):
  - All 32 registers become 0.
  - FSM goes to IDLE and the index counter goes to 0.
  - dump_valid, dump_busy and dump_done are 0.
  - Reset has priority over a write and over every FSM activity, including mid-dump; no done pulse is produced.
- Write:
  - On a rising edge with RUWr=1 and rd!=0, regs[rd] <= DataWr.
  - Writes with rd=0 are discarded; x0 always reads 0.
- Read:
  - Combinational, zero latency.
  - RURsN = 0 when rsN=0, else regs[rsN], subject to the Optional Feature.
- Dump FSM states: IDLE, DUMP, DONE.
  - IDLE: dump_start=1 -> DUMP with idx=0.
  - DUMP: dump_valid=1, dump_idx=idx, dump_data=regs[idx] (x0 reads 0; no bypass).
    - A beat transfers when dump_valid && dump_ready.
    - On a transfer with idx<31, idx increments.
    - On a transfer with idx=31 -> DONE.
    - Without dump_ready, idx and dump_data hold. dump_data still tracks any write to regs[idx] on the next cycle.
  - DONE: dump_done=1 for exactly one cycle, then -> IDLE, idx=0.
  - dump_busy=1 in DUMP and DONE.
  - dump_start while busy is ignored; it is neither queued nor restarted.
- Timing:
  - Minimum dump length is 32 transfer cycles plus 1 DONE cycle.
  - A write on the same edge as a transfer lands in the register file and does not stall the dump.
- Outputs not in use: dump_idx and dump_data are 0 outside DUMP.

Optional Feature:
- Macro: RU_WRITE_BYPASS_EN.
- Defined:
  - RURsN = DataWr when RUWr=1, rd!=0 and rd==rsN; otherwise the normal read.
  - This gives write-before-read semantics within one cycle, for future pipelining.
- Undefined:
  - RURsN always returns the stored value, so the new value is visible only after the edge.
  - This is the default for the monocycle core.

Test Plan:
- Reset, then rs1=5, rs2=31 -> RURs1=0, RURs2=0. Dump from reset -> 32 beats, all data 0, then dump_done pulse.
- Write rd=5 with DataWr=0x12345678 and RUWr=1 -> next cycle rs1=5 gives 0x12345678. Same cycle with rs1=5:
  - macro undefined -> 0.
  - macro defined -> 0x12345678.
- Write rd=0 with DataWr=0xCAFEBABE and RUWr=1 -> rs1=0 and rs2=0 read 0x00000000. Dump beat idx 0 = 0.
- Write regs[i]=0x100+i for i=1..31, pulse dump_start, toggle dump_ready every other cycle:
  - 32 beats, each idx/data = 0x100+i (idx 0 -> 0).
  - dump_idx and dump_data hold while ready=0.
  - dump_done high exactly one cycle after idx 31 is accepted; dump_busy falls the cycle after.
- During DUMP at idx=3 with ready=0, write rd=3 with DataWr=0xDEADBEEF -> next cycle dump_data=0xDEADBEEF. A second dump_start here is ignored (idx stays 3).
- rst_n low at dump idx=10 -> next cycle dump_busy=0, dump_valid=0, dump_done=0, and all registers read 0.
